tank_slot_timer_f1: RTL

// - Upstream timing/selection stage for the F1 tank decoder; one clk = one digit time.
// - Tracks recirculation position (digit within minor cycle, minor cycle within tank).
// - Holds one memory request, waits for the addressed minor cycle, then drives the decoder for that slot.
// - Drives the read/write gates and the one-hot up/down tank selects.

---
 rtl/tank_slot_timer_f1_if.sv | 23 ++
 rtl/tank_slot_timer_f1.sv | 156 +++++++++++++++
 2 files changed

// File: rtl/tank_slot_timer_f1_if.sv
// Request handshake between a memory requester and the F1 tank slot timer.
// The req_long field exists only when TANK_LONG_WORD_EN is defined.
interface tank_slot_timer_f1_if #(
  parameter int SLOT_W = 5
);
  logic              req;
  logic              req_write;
  logic [SLOT_W+2:0] req_addr;
`ifdef TANK_LONG_WORD_EN
  logic              req_long;
`endif
  logic              req_ready;
  logic              busy;
  logic              done;

`ifdef TANK_LONG_WORD_EN
  modport master (output req, req_write, req_addr, req_long, input req_ready, busy, done);
  modport slave  (input req, req_write, req_addr, req_long, output req_ready, busy, done);
`else
  modport master (output req, req_write, req_addr, input req_ready, busy, done);
  modport slave  (input req, req_write, req_addr, output req_ready, busy, done);
`endif
endinterface

// File: rtl/tank_slot_timer_f1.sv
// Recirculation position counters and single-request slot sequencer for the F1 tank decoder.
// Optional two-slot transfers are built when TANK_LONG_WORD_EN is defined.
//
// state  | meaning
// S_IDLE | ready, accepts one request
// S_WAIT | request latched, waiting for the last digit before the target slot
// S_XFER | gate and tank select driven for the target slot (or slot pair)
// S_DONE | one-cycle completion pulse, requests ignored
module tank_slot_timer_f1 #(
  parameter int DIGITS = 18,
  parameter int SLOT_W = 5
) (
  input  logic                clk,
  input  logic                cls,
  tank_slot_timer_f1_if.slave req_if,
  output logic                f1_read,
  output logic                f1_write,
  output logic [3:0]          f1_up_sel,
  output logic [3:0]          f1_down_sel,
  output logic [4:0]          digit_pos,
  output logic [SLOT_W-1:0]   minor_pos
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_XFER, S_DONE} state_t;

  localparam logic [4:0] DIGIT_LAST = 5'(DIGITS - 1);

  state_t            state_q, state_d;
  logic [4:0]        digit_q, digit_d;
  logic [SLOT_W-1:0] minor_q, minor_d;
  logic              write_q, write_d;
  logic              half_q, half_d;
  logic [1:0]        tank_q, tank_d;
  logic [SLOT_W-1:0] slot_q, slot_d;
`ifdef TANK_LONG_WORD_EN
  logic              long_q, long_d;
`endif
  logic              ready_q, ready_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              rd_q, rd_d;
  logic              wr_q, wr_d;
  logic [3:0]        up_q, up_d;
  logic [3:0]        down_q, down_d;

  logic              digit_last;
  logic [SLOT_W-1:0] minor_inc;
  logic              xfer_last;
  logic              to_xfer;
  logic [3:0]        tank_1h;

  assign digit_last = (digit_q == DIGIT_LAST);
  assign minor_inc  = minor_q + SLOT_W'(1);
  assign tank_1h    = 4'b0001 << tank_q;

`ifdef TANK_LONG_WORD_EN
  // A long transfer starts on the even slot and ends after the odd one.
  assign xfer_last = digit_last && (!long_q || minor_q[0]);
`else
  assign xfer_last = digit_last;
`endif

  always_comb begin
    digit_d = digit_last ? 5'd0 : digit_q + 5'd1;
    minor_d = digit_last ? minor_inc : minor_q;
    state_d = state_q;
    write_d = write_q;
    half_d  = half_q;
    tank_d  = tank_q;
    slot_d  = slot_q;
`ifdef TANK_LONG_WORD_EN
    long_d  = long_q;
`endif
    case (state_q)
      S_IDLE: begin
        if (req_if.req) begin
          write_d = req_if.req_write;
          half_d  = req_if.req_addr[SLOT_W+2];
          tank_d  = req_if.req_addr[SLOT_W+1:SLOT_W];
`ifdef TANK_LONG_WORD_EN
          long_d  = req_if.req_long;
          slot_d  = req_if.req_addr[SLOT_W-1:0] & ~SLOT_W'(req_if.req_long);
`else
          slot_d  = req_if.req_addr[SLOT_W-1:0];
`endif
          state_d = S_WAIT;
        end
      end
      // Entering XFER on the wrap into the target slot aligns it with digit 0.
      S_WAIT:  if (digit_last && (minor_inc == slot_q)) state_d = S_XFER;
      S_XFER:  if (xfer_last) state_d = S_DONE;
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase

    to_xfer = (state_d == S_XFER);
    ready_d = (state_d == S_IDLE);
    busy_d  = (state_d == S_WAIT) || to_xfer;
    done_d  = (state_d == S_DONE);
    rd_d    = to_xfer && !write_q;
    wr_d    = to_xfer && write_q;
    up_d    = (to_xfer && half_q)  ? tank_1h : 4'b0000;
    down_d  = (to_xfer && !half_q) ? tank_1h : 4'b0000;
  end

  always_ff @(posedge clk) begin
    if (cls) begin
      state_q <= S_IDLE;
      digit_q <= '0;
      minor_q <= '0;
      write_q <= 1'b0;
      half_q  <= 1'b0;
      tank_q  <= '0;
      slot_q  <= '0;
`ifdef TANK_LONG_WORD_EN
      long_q  <= 1'b0;
`endif
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      rd_q    <= 1'b0;
      wr_q    <= 1'b0;
      up_q    <= '0;
      down_q  <= '0;
    end else begin
      state_q <= state_d;
      digit_q <= digit_d;
      minor_q <= minor_d;
      write_q <= write_d;
      half_q  <= half_d;
      tank_q  <= tank_d;
      slot_q  <= slot_d;
`ifdef TANK_LONG_WORD_EN
      long_q  <= long_d;
`endif
      ready_q <= ready_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      rd_q    <= rd_d;
      wr_q    <= wr_d;
      up_q    <= up_d;
      down_q  <= down_d;
    end
  end

  assign req_if.req_ready = ready_q;
  assign req_if.busy      = busy_q;
  assign req_if.done      = done_q;
  assign f1_read          = rd_q;
  assign f1_write         = wr_q;
  assign f1_up_sel        = up_q;
  assign f1_down_sel      = down_q;
  assign digit_pos        = digit_q;
  assign minor_pos        = minor_q;

endmodule
